motor_ramp: RTL and testbench

Slew-rate limiter and direction sequencer sitting directly upstream of the `pwm` generator in each motor channel. It accepts signed speed commands over a valid/ready handshake and ramps an unsigned duty magnitude toward the commanded value at a fixed rate. The magnitude feeds `pwm.in` and a direction bit goes to the H-bridge. Sign reversals are always sequenced as brake to zero, hold, flip direction, then ramp up, so the bridge never reverses under load.

---
 rtl/motor_ramp_pkg.sv | 15 +
 rtl/motor_ramp.sv | 137 +++++++++++++
 tb/tb_motor_ramp.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/motor_ramp_pkg.sv
// rtl/motor_ramp_pkg.sv - shared defaults and state type for the motor ramp channel
package motor_ramp_pkg;

    localparam int RAMP_RES      = 8;
    localparam int RAMP_STEP     = 4;
    localparam int RAMP_TICK_DIV = 10;
    localparam int RAMP_DIR_HOLD = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_BRAKE = 2'd1,
        ST_HOLD  = 2'd2
    } ramp_state_e;

endpackage

// File: rtl/motor_ramp.sv
// rtl/motor_ramp.sv - slew-rate limiter and brake/hold/flip direction sequencer ahead of pwm
module motor_ramp
    import motor_ramp_pkg::*;
#(
    parameter int nbits    = RAMP_RES,
    parameter int step     = RAMP_STEP,
    parameter int tick_div = RAMP_TICK_DIV,
    parameter int dir_hold = RAMP_DIR_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [nbits:0]   cmd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [nbits-1:0] duty,
    output logic             dir,
    output logic             at_target
);

    localparam int DIV_W  = (tick_div > 1) ? $clog2(tick_div) : 1;
    localparam int HOLD_W = (dir_hold > 1) ? $clog2(dir_hold) : 1;
    localparam logic [nbits:0]   STEP_X  = (nbits + 1)'(step);
    localparam logic [nbits-1:0] MAG_MAX = '1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(tick_div - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(dir_hold - 1);

    generate
        if (step < 1 || tick_div < 1 || dir_hold < 1 || step > (2 ** nbits) - 1) begin : g_bad_param
            $error("motor_ramp: invalid step/tick_div/dir_hold for nbits");
        end
    endgenerate

    ramp_state_e       state, state_nxt;
    logic [nbits-1:0]  duty_nxt, tgt_mag, tgt_mag_nxt;
    logic              dir_nxt, tgt_dir, tgt_dir_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              tick, accept;
    logic [nbits:0]    cmd_abs;
    logic [nbits-1:0]  cmd_mag;

    // Move cur toward tgt by at most STEP_X; widened by one bit so nothing wraps.
    function automatic logic [nbits-1:0] approach(input logic [nbits-1:0] cur,
                                                  input logic [nbits-1:0] tgt);
        logic [nbits:0] c, t;
        c = {1'b0, cur};
        t = {1'b0, tgt};
        if (c < t)
            return ((t - c) > STEP_X) ? nbits'(c + STEP_X) : tgt;
        else
            return ((c - t) > STEP_X) ? nbits'(c - STEP_X) : tgt;
    endfunction

    assign tick      = en && (div_cnt == DIV_LAST);
    assign cmd_ready = en && (state == ST_RUN);
    assign accept    = cmd_valid && cmd_ready;
    assign at_target = (state == ST_RUN) && (duty == tgt_mag);

    // Only -2^nbits has a magnitude that does not fit; it saturates to full scale.
    assign cmd_abs = cmd[nbits] ? (~cmd + (nbits + 1)'(1)) : cmd;
    assign cmd_mag = cmd_abs[nbits] ? MAG_MAX : cmd_abs[nbits-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            duty     <= '0;
            dir      <= 1'b0;
            tgt_mag  <= '0;
            tgt_dir  <= 1'b0;
            div_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            dir      <= dir_nxt;
            tgt_mag  <= tgt_mag_nxt;
            tgt_dir  <= tgt_dir_nxt;
            div_cnt  <= div_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        duty_nxt    = duty;
        dir_nxt     = dir;
        tgt_mag_nxt = tgt_mag;
        tgt_dir_nxt = tgt_dir;
        div_nxt     = div_cnt;
        hold_nxt    = hold_cnt;
        if (!en) begin
            // dir deliberately survives a disable so the bridge does not flip.
            state_nxt   = ST_RUN;
            duty_nxt    = '0;
            tgt_mag_nxt = '0;
            div_nxt     = '0;
            hold_nxt    = '0;
        end else begin
            div_nxt = tick ? '0 : div_cnt + DIV_W'(1);
            case (state)
                ST_RUN: begin
                    if (tick)
                        duty_nxt = approach(duty, tgt_mag);
                    if (accept) begin
                        tgt_mag_nxt = cmd_mag;
                        if (cmd_mag != '0 && cmd[nbits] != dir) begin
                            tgt_dir_nxt = cmd[nbits];
                            state_nxt   = ST_BRAKE;
                        end
                    end
                end
                ST_BRAKE: begin
                    if (duty == '0) begin
                        state_nxt = ST_HOLD;
                        hold_nxt  = '0;
                    end else if (tick) begin
                        duty_nxt = approach(duty, '0);
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            dir_nxt   = tgt_dir;
                            state_nxt = ST_RUN;
                            hold_nxt  = '0;
                        end else begin
                            hold_nxt = hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_ramp.sv
// tb/tb_motor_ramp.sv - directed and randomized checks of motor_ramp against a behavioural model
module tb_motor_ramp;

    localparam int NB = 8;
    localparam int ST = 4;
    localparam int TD = 10;
    localparam int DH = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [NB:0]   cmd = '0;
    logic          cmd_ready;
    logic [NB-1:0] duty;
    logic          dir;
    logic          at_target;

    int  n_cmp = 0;
    int  n_err = 0;
    bit  rst_req = 1'b1;

    // Behavioural model: integer duty/target, a "reversing" flag and a
    // "waiting at zero" flag with a tick count.
    int  m_duty, m_tgt, m_div, m_hold;
    bit  m_dir, m_tdir, m_en, m_rev, m_holding;

    motor_ramp #(.nbits(NB), .step(ST), .tick_div(TD), .dir_hold(DH)) dut (
        .clk(clk), .rst(rst), .en(en), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .duty(duty), .dir(dir), .at_target(at_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int toward(input int cur, input int tgt);
        if (cur < tgt) return (tgt - cur > ST) ? cur + ST : tgt;
        return (cur - tgt > ST) ? cur - ST : tgt;
    endfunction

    task automatic model_reset();
        m_duty = 0; m_tgt = 0; m_div = 0; m_hold = 0;
        m_dir = 0; m_tdir = 0; m_rev = 0; m_holding = 0;
        m_en = en;
    endtask

    task automatic model_edge();
        int v, mag;
        bit tick, d;
        if (rst) begin
            model_reset();
            return;
        end
        if (!en) begin
            m_duty = 0; m_tgt = 0; m_div = 0; m_hold = 0; m_rev = 0; m_holding = 0;
            m_en = en;
            return;
        end
        tick  = (m_div == TD - 1);
        m_div = tick ? 0 : m_div + 1;
        if (!m_rev) begin
            if (tick) m_duty = toward(m_duty, m_tgt);
            if (cmd_valid) begin
                v   = int'($signed(cmd));
                mag = (v < 0) ? -v : v;
                if (mag > (1 << NB) - 1) mag = (1 << NB) - 1;
                d     = (v < 0);
                m_tgt = mag;
                if (mag != 0 && d != m_dir) begin
                    m_rev = 1; m_holding = 0; m_tdir = d;
                end
            end
        end else if (!m_holding) begin
            if (m_duty == 0) begin
                m_holding = 1; m_hold = 0;
            end else if (tick) begin
                m_duty = toward(m_duty, 0);
            end
        end else if (tick) begin
            m_hold++;
            if (m_hold == DH) begin
                m_dir = m_tdir; m_rev = 0; m_holding = 0; m_hold = 0;
            end
        end
        m_en = en;
    endtask

    task automatic check_outputs();
        chk("duty", 32'(duty), 32'(m_duty));
        chk("dir", 32'(dir), 32'(m_dir));
        chk("cmd_ready", 32'(cmd_ready), 32'(m_en && !m_rev));
        chk("at_target", 32'(at_target), 32'(!m_rev && m_duty == m_tgt));
    endtask

    task automatic step(input bit e, input bit v, input logic [NB:0] c);
        @(negedge clk);
        check_outputs();
        rst       = rst_req;
        en        = e;
        cmd_valid = v;
        cmd       = c;
        model_edge();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, '0);
    endtask

    function automatic logic [NB:0] sc(input int v);
        return (NB + 1)'(v);
    endfunction

    initial begin
        logic [NB:0] specials [6];
        logic [NB:0] c;
        specials = '{sc(0), sc(-256), sc(255), sc(-255), sc(1), sc(-1)};
        model_reset();

        step(1'b0, 1'b0, '0);
        rst_req = 1'b0;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        chk("reset_ready_en", 32'(cmd_ready), 32'd1);

        step(1'b1, 1'b1, sc(100));
        idle(300);
        chk("ramp100_duty", 32'(duty), 32'd100);
        chk("ramp100_at_target", 32'(at_target), 32'd1);
        chk("ramp100_dir", 32'(dir), 32'd0);

        step(1'b1, 1'b1, sc(102));
        idle(12);
        chk("clamp102_duty", 32'(duty), 32'd102);

        step(1'b1, 1'b1, sc(-50));
        step(1'b1, 1'b0, '0);
        chk("rev_ready_low", 32'(cmd_ready), 32'd0);
        idle(520);
        chk("rev50_duty", 32'(duty), 32'd50);
        chk("rev50_dir", 32'(dir), 32'd1);

        step(1'b1, 1'b1, sc(-40));
        idle(30);
        chk("down40_duty", 32'(duty), 32'd40);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, sc(100));
        chk("en_clear_duty", 32'(duty), 32'd0);
        chk("en_clear_ready", 32'(cmd_ready), 32'd0);
        chk("en_clear_dir", 32'(dir), 32'd1);
        idle(50);
        chk("en_back_duty", 32'(duty), 32'd0);

        step(1'b1, 1'b1, sc(-256));
        idle(700);
        chk("sat_duty", 32'(duty), 32'd255);
        chk("sat_dir", 32'(dir), 32'd1);

        step(1'b1, 1'b1, sc(200));
        idle(100);
        chk("brake_ready_low", 32'(cmd_ready), 32'd0);
        #2 rst = 1'b1;
        rst_req = 1'b1;
        model_reset();
        #1;
        chk("async_rst_duty", 32'(duty), 32'd0);
        chk("async_rst_dir", 32'(dir), 32'd0);
        chk("async_rst_ready", 32'(cmd_ready), 32'd1);
        chk("async_rst_at_target", 32'(at_target), 32'd1);
        idle(2);
        rst_req = 1'b0;
        idle(150);
        chk("post_rst_dir", 32'(dir), 32'd0);
        chk("post_rst_duty", 32'(duty), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) c = specials[$urandom_range(0, 5)];
            else c = (NB + 1)'($urandom_range(0, 511));
            step($urandom_range(0, 63) != 0, $urandom_range(0, 29) == 0, c);
        end
        step(1'b1, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
